// File: rtl/lsu_dmem.sv
// Load/store unit between the single-cycle datapath and a word-wide data RAM.
// Handles byte/half/word loads and stores, splits misaligned accesses into two
// aligned word transactions and stalls the datapath until the access retires.
module lsu_dmem #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-3:0] m_addr,
  output logic [3:0]        m_wstrb,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  input  logic              m_ready
);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StDone} state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;

  function automatic logic is_legal(input logic st, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return !st;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && (off == 2'b11)) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Strobes/data for the first word: mask and data shifted up by the byte offset.
  function automatic logic [3:0] strb_lo(input logic [2:0] f3, input logic [1:0] off);
    return size_mask(f3) << off;
  endfunction

  // Second word gets the bits shifted out of the first (zero when off=0).
  function automatic logic [3:0] strb_hi(input logic [2:0] f3, input logic [1:0] off);
    return size_mask(f3) >> (3'd4 - {1'b0, off});
  endfunction

  function automatic logic [31:0] data_lo(input logic [31:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  function automatic logic [31:0] data_hi(input logic [31:0] d, input logic [1:0] off);
    return d >> (6'd32 - {1'b0, off, 3'b000});
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [63:0] raw);
    logic [31:0] sh;
    sh = 32'(raw >> {off, 3'b000});
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b010:  return sh;
      3'b100:  return {24'b0, sh[7:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return '0;
    endcase
  endfunction

  logic cap_split;

  // Split decision for the access currently in flight.
  always_comb begin
    cap_split = is_split(f3_q, off_q);
  end

  // Hold the datapath while a request is pending or the memory is busy.
  always_comb begin
    stall = ((state_q == StIdle) && req) || (state_q == StAcc0) || (state_q == StAcc1);
  end

  // Access FSM; all memory-side and result outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wstrb <= '0;
      m_wdata <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            we_q    <= we;
            f3_q    <= func3;
            off_q   <= addr[1:0];
            wdata_q <= wdata;
            if (!is_legal(we, func3)) begin
              state_q <= StDone;
              done    <= 1'b1;
              err     <= 1'b1;
              rdata   <= '0;
            end else begin
              state_q <= StAcc0;
              m_req   <= 1'b1;
              m_we    <= we;
              m_addr  <= addr[ADDR_W-1:2];
              m_wstrb <= we ? strb_lo(func3, addr[1:0]) : 4'b0000;
              m_wdata <= we ? data_lo(wdata, addr[1:0]) : 32'b0;
            end
          end
        end
        StAcc0: begin
          if (m_ready) begin
            lo_q <= m_rdata;
            if (cap_split) begin
              state_q <= StAcc1;
              m_addr  <= m_addr + 1'b1;  // wraps modulo the word space
              m_wstrb <= we_q ? strb_hi(f3_q, off_q) : 4'b0000;
              m_wdata <= we_q ? data_hi(wdata_q, off_q) : 32'b0;
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
              m_req   <= 1'b0;
              m_we    <= 1'b0;
              m_wstrb <= '0;
              m_wdata <= '0;
              rdata   <= we_q ? 32'b0 : load_ext(f3_q, off_q, {32'b0, m_rdata});
            end
          end
        end
        StAcc1: begin
          if (m_ready) begin
            state_q <= StDone;
            done    <= 1'b1;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_wstrb <= '0;
            m_wdata <= '0;
            rdata   <= we_q ? 32'b0 : load_ext(f3_q, off_q, {m_rdata, lo_q});
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem with a wait-state memory model and scoreboards
// for both the memory transactions and the load results.
module tb_lsu_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [29:0] m_addr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  always #5 clk = ~clk;

  lsu_dmem #(.ADDR_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .func3   (func3),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .stall   (stall),
    .done    (done),
    .err     (err),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wstrb (m_wstrb),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready)
  );

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [31:0] rd;
    logic        e;
    int          n;
  } res_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  res_t res_q[$];
  int   obs_rd = 0;

  int n_err = 0;
  int n_checks = 0;

  // Memory model: small array indexed by low word-address bits, fixed wait states.
  logic [31:0] mem [16];
  int unsigned wait_cfg = 0;
  int unsigned wait_left = 0;

  always_comb m_rdata = mem[m_addr[3:0]];
  assign m_ready = m_req && (wait_left == 0);

  always @(posedge clk) begin
    if (!m_req || m_ready) wait_left <= wait_cfg;
    else wait_left <= wait_left - 1;
  end

  // Record every completed memory transaction.
  always @(posedge clk) begin
    if (!rst && m_req && m_ready)
      obs_q.push_back('{m_we, m_addr, m_we ? m_wstrb : 4'b0, m_we ? m_wdata : 32'b0});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_txn(input logic w, input logic [29:0] a, input logic [3:0] s,
                          input logic [31:0] d);
    exp_q.push_back('{w, a, s, d});
  endtask

  task automatic check_txns(input string tag);
    txn_t e;
    txn_t o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        o = obs_q[obs_rd];
        obs_rd++;
        chk({tag, "_we"},   {31'b0, o.we}, {31'b0, e.we});
        chk({tag, "_addr"}, {2'b0, o.addr}, {2'b0, e.addr});
        chk({tag, "_strb"}, {28'b0, o.strb}, {28'b0, e.strb});
        chk({tag, "_data"}, o.data, e.data);
      end else begin
        chk({tag, "_txn_missing"}, 32'd0, 32'd1);
      end
    end
    chk({tag, "_txn_extra"}, 32'(obs_q.size() - obs_rd), 32'd0);
  endtask

  // Issue one instruction at a negedge and follow it to its done pulse.
  task automatic do_op(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int unsigned waits,
                       input logic [31:0] exp_rd, input logic exp_e, input int exp_n);
    int   n;
    logic seen;
    logic [67:0] prev;
    logic        prev_wait;
    res_t r;
    res_q.push_back('{exp_rd, exp_e, exp_n});
    wait_cfg = waits;
    req = 1'b1; we = w; func3 = f3; addr = a; wdata = d;
    #1;
    chk({tag, "_stall_idle"}, {31'b0, stall}, 32'd1);
    prev = {m_req, m_we, m_addr, m_wstrb, m_wdata};
    prev_wait = m_req && !m_ready;
    n = 1;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        chk({tag, "_stall_busy"}, {31'b0, stall}, 32'd1);
        if (prev_wait)
          chk({tag, "_bus_hold"},
              {31'b0, ({m_req, m_we, m_addr, m_wstrb, m_wdata} === prev)}, 32'd1);
      end
      prev = {m_req, m_we, m_addr, m_wstrb, m_wdata};
      prev_wait = m_req && !m_ready;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      r = res_q.pop_front();
      chk({tag, "_cycles"}, 32'(n), 32'(r.n));
      chk({tag, "_rdata"}, rdata, r.rd);
      chk({tag, "_err"}, {31'b0, err}, {31'b0, r.e});
      chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
    end
    req = 1'b0;
    check_txns(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, "_idle_quiet"}, {30'b0, stall, m_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; func3 = 3'b000; addr = '0; wdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {rdata[0], done, err, m_req, m_we, stall}, 32'd0);
    chk("rst_bus", {m_wstrb, m_addr[27:0]} | m_wdata | rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    push_txn(1'b1, 30'h40, 4'b1111, 32'hDEADBEEF);
    do_op("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1'b0, 3);

    mem[0] = 32'h80FF_0000;
    push_txn(1'b0, 30'h40, 4'b0000, 32'h0);
    do_op("lb", 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'hFFFFFF80, 1'b0, 3);
    push_txn(1'b0, 30'h40, 4'b0000, 32'h0);
    do_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h00000080, 1'b0, 3);

    push_txn(1'b1, 30'h80, 4'b1000, 32'h3400_0000);
    push_txn(1'b1, 30'h81, 4'b0001, 32'h0000_0012);
    do_op("sh_split", 1'b1, 3'b001, 32'h203, 32'h1234, 0, 32'h0, 1'b0, 4);

    push_txn(1'b1, 30'h40, 4'b0100, 32'hAA5A_0000);
    do_op("sb", 1'b1, 3'b000, 32'h102, 32'hAAAA_AA5A, 0, 32'h0, 1'b0, 3);

    push_txn(1'b1, 30'h40, 4'b1110, 32'h2233_4400);
    push_txn(1'b1, 30'h41, 4'b0001, 32'h0000_0011);
    do_op("sw_split", 1'b1, 3'b010, 32'h101, 32'h1122_3344, 0, 32'h0, 1'b0, 4);

    do_op("ill_load", 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1'b1, 2);
    do_op("ill_store", 1'b1, 3'b100, 32'h100, 32'h5555_5555, 0, 32'h0, 1'b1, 2);

    mem[0] = 32'h8001_1234;
    push_txn(1'b0, 30'h0, 4'b0000, 32'h0);
    do_op("lh_wait", 1'b0, 3'b001, 32'h2, 32'h0, 1, 32'hFFFF8001, 1'b0, 4);

    mem[0] = 32'hAB00_0000;
    mem[1] = 32'h0000_00CD;
    push_txn(1'b0, 30'h0, 4'b0000, 32'h0);
    push_txn(1'b0, 30'h1, 4'b0000, 32'h0);
    do_op("lhu_split", 1'b0, 3'b101, 32'h3, 32'h0, 0, 32'h0000CDAB, 1'b0, 4);

    mem[0] = 32'h4433_2211;
    mem[1] = 32'h8877_6655;
    push_txn(1'b0, 30'h0, 4'b0000, 32'h0);
    push_txn(1'b0, 30'h1, 4'b0000, 32'h0);
    do_op("lw_split_wait", 1'b0, 3'b010, 32'h1, 32'h0, 2, 32'h5544_3322, 1'b0, 8);

    // Split load at the top of memory, reset while the second half is pending.
    wait_cfg = 1;
    push_txn(1'b0, 30'h3FFF_FFFF, 4'b0000, 32'h0);
    req = 1'b1; we = 1'b0; func3 = 3'b010; addr = 32'hFFFF_FFFD;
    @(negedge clk);
    chk("wrap_acc0_addr", {2'b0, m_addr}, 32'h3FFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_acc1_req", {31'b0, m_req}, 32'd1);
    chk("wrap_acc1_addr", {2'b0, m_addr}, 32'h0);
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ctrl", {26'b0, done, err, m_req, m_we, stall, 1'b0}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_addr", {2'b0, m_addr}, 32'd0);
    chk("midrst_wr", {28'b0, m_wstrb} | m_wdata, 32'd0);
    @(negedge clk);
    chk("midrst_no_second", {31'b0, m_req}, 32'd0);
    check_txns("midrst");

    mem[0] = 32'hCAFE_F00D;
    push_txn(1'b0, 30'h0, 4'b0000, 32'h0);
    do_op("lw_recover", 1'b0, 3'b010, 32'h0, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_dmem.md
# lsu_dmem

Load/store unit sitting directly downstream of the single-cycle datapath: consumes the datapath's ALU result (effective address), store data, func3 and memory-control strobes. It drives a word-wide data RAM port with a req/ready handshake and returns the sign- or zero-extended load value for write-back. Misaligned halfword and word accesses are split into two aligned word transactions. A stall output holds the datapath PC until the access completes.

## Interface
- ADDR_W, 32, byte-address width from datapath
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  load/store present this instruction; held stable with all request inputs while stall=1
- we  in  1  1 = store, 0 = load
- func3  in  3  RV32 width/sign code
- addr  in  32  effective byte address (ALU result)
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load result, valid when done=1
- stall  out  1  datapath must not advance
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for illegal func3
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  30  word address
- m_wstrb  out  4  byte strobes, bit i = byte lane i
- m_wdata  out  32  lane-positioned write data
- m_rdata  in  32  read word, valid in cycle m_ready=1
- m_ready  in  1  memory accepts/completes; may be 1 in same cycle as m_req

## Operation
- func3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); stores accept 000/001/010 only. Others (incl. BU/HU on store) illegal.
- off = addr[1:0]. Split when (H/HU and off=3) or (W and off≠0). Second word address = addr[31:2]+1, wrapping modulo 2^30.
- FSM: IDLE, ACC0, ACC1, DONE.
- IDLE: if req, capture we/func3/addr/wdata; illegal → DONE with err; else → ACC0.
- ACC0: m_req=1, m_addr=addr[31:2]; on m_ready: capture m_rdata into lo buffer; split → ACC1 else → DONE.
- ACC1: m_req=1, m_addr=word+1; on m_ready capture hi buffer → DONE.
- DONE: done=1, stall=0; → IDLE unconditionally.
- m_req, m_addr, m_we, m_wstrb, m_wdata stable while m_req=1 and m_ready=0.
- Store lanes: data = wdata shifted left by 8·off. First access strobes = size mask (B=0001,H=0011,W=1111) shifted left by off, truncated to 4 bits; second access strobes = bits shifted out (mask<<off)>>4, data = wdata >> 8·(4−off).
- Load assembly: 64-bit {hi,lo} >> 8·off, take low 8/16/32 bits; B/H sign-extend bit 7/15, BU/HU zero-extend.
- rdata registered, holds last value until next DONE; 0 for stores and illegal codes.

## Timing
- stall = (state=IDLE & req) | state∈{ACC0,ACC1}; combinational.
- Latency from req (IDLE) to done, zero-wait memory: aligned 3 cycles (IDLE, ACC0, DONE); split 4; illegal 2. Each memory wait cycle adds 1.
- Datapath advances on the edge ending the DONE cycle; next instruction's req seen in following IDLE cycle — no retrigger.
- Reset: state=IDLE, rdata=0, done=0, err=0, m_req=0, m_we=0, m_addr=0, m_wstrb=0, m_wdata=0. Reset mid-access abandons it (no second half issued); memory must tolerate dropped req.
- req=0 in IDLE: stall=0, no memory activity. m_we=0 whenever m_req=0.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, zero-wait → one access m_addr=0x40, wstrb=1111, m_wdata=0xDEADBEEF; done in cycle 3.
- LB addr=0x103, m_rdata=0x80FF_0000 → rdata=0xFFFFFF80; LBU same → 0x00000080.
- SH addr=0x203, wdata=0x1234 → acc0 m_addr=0x80 wstrb=1000 data byte3=0x34; acc1 m_addr=0x81 wstrb=0001 byte0=0x12; done cycle 4.
- LW addr=0x0001, words 0x44332211 / 0x88776655 with 2 wait cycles each → rdata=0x55443322, done after 8 cycles, stall high throughout until DONE.
- func3=011 load → no m_req, err=1 and done=1 in cycle 2, rdata=0.
- rst asserted in ACC1 of split load → next cycle IDLE, m_req=0, all outputs at reset values; LW addr=0xFFFFFFFD second access wraps to m_addr=0x0.
